fwd_id_ex_stage: RTL and testbench
==================================

// Module: fwd_id_ex_stage
// PURPOSE
//  Parametrised ID->EX pipeline stage for the pipelined MIPS machine. Registers the
//  decoded operands and control bundle, and forwards from the live writeback plus a
//  DEPTH-entry writeback history. It detects load-use hazards and inserts one bubble.
//  It supports branch flush. Sits between mips_decode/regfile and alu32.
// PARAMETERS
//  DW      32  data width of operands, immediate and writeback data
//  RW      5   register-number width
//  CW      16  opaque control-bundle width (ALUOp, MemWrite, ...)
//  DEPTH   2   writeback-history entries used for forwarding; legal range 1..4
// PORTS
//  clk           in   1    clock, rising edge
//  reset         in   1    synchronous, active-high
//  id_valid      in   1    ID holds a real instruction
//  id_rs,id_rt   in   RW   source register numbers
//  id_uses_rs/rt in   1    instruction actually reads rs / rt
//  id_rd1,id_rd2 in   DW   regfile read data
//  id_imm        in   DW   sign-extended immediate
//  id_ctrl       in   CW   control bundle
//  id_reg_write  in   1    instruction writes a register
//  id_is_load    in   1    instruction is a load (MemRead)
//  id_wr_regnum  in   RW   destination register
//  flush         in   1    taken branch: squash ID instruction
//  wb_en         in   1    writeback this cycle
//  wb_regnum     in   RW   writeback destination
//  wb_data       in   DW   writeback value
//  stall_id      out  1    hold PC and IF/ID this cycle (combinational)
//  ex_valid      out  1    EX holds a real instruction
//  ex_ctrl       out  CW   registered control; 0 when ex_valid=0
//  ex_reg_write, ex_is_load out 1; ex_wr_regnum out RW   registered, gated by ex_valid
//  ex_imm        out  DW   registered immediate
//  ex_a, ex_b    out  DW   forwarded rs / rt operand (combinational from registers + wb)
// BEHAVIOUR
//  - Reset: all ex_* registers 0, ex_valid=0, all history entries invalid.
//    stall_id=0 while reset is high.
//  - Latency: 1 cycle ID->EX. An accepted instruction appears on ex_* the next cycle.
//  - History: each cycle hist[0] <= {wb_en,wb_regnum,wb_data} and
//    hist[i] <= hist[i-1]. Entries hold a valid bit; reset clears it.
//  - Forwarding for ex_a (same for ex_b with rt): pick the first match in priority order.
//    Order: live wb port > hist[0] > ... > hist[DEPTH-1] > registered id_rd1.
//    A match means valid && regnum==ex_rs && ex_rs!=0. Register 0 always reads the
//    registered value, never forwarded.
//  - Load-use: the hazard condition is ex_valid & ex_is_load & ex_wr_regnum!=0 & id_valid,
//    AND (id_uses_rs & id_rs==ex_wr_regnum | id_uses_rt & id_rt==ex_wr_regnum).
//    stall_id=1 for exactly that cycle. EX loads a bubble (ex_valid=0, ctrl=0).
//    ID operands are not captured.
//  - Flush: EX loads a bubble. stall_id forced 0, because the flushed instruction is dead.
//    Flush wins over load-use.
//  - Bubble: a bubble never matches hazards. It also never drives ex_reg_write.
//  - Stall repeats: the load has left EX after one bubble, so a second consecutive stall
//    for the same pair is impossible. The bench checks that stall_id is never high two
//    consecutive cycles for one load.
//  - Reset mid-stream: the pipeline and history are cleared on the same edge. No forward
//    of pre-reset data is permitted after the reset edge.
// CONFIGURATION
//  STALL_STATS_EN defined:
//   - Adds outputs stat_stalls[31:0], stat_flushes[31:0], stat_fwds[31:0].
//   - They count, respectively: cycles with stall_id=1; cycles with flush=1 & reset=0;
//     and cycles where ex_valid & (ex_a or ex_b is forwarded).
//   - Counters saturate at 32'hFFFFFFFF and reset to 0.
//  STALL_STATS_EN undefined: no counters and no extra ports. Core behaviour is identical.
// TESTING
//  1 reset, then idle -> ex_valid=0, ex_ctrl=0, stall_id=0, ex_a=ex_b=0
//  2 add $3 (wb $3=0x11) then use $3 next cycle -> ex_a=0x11 from live wb, not stale id_rd1
//  3 DEPTH=2: wb $5=0xAA at t, $5=0xBB at t+1, use at t+2 -> ex_a=0xBB (newest wins)
//  4 lw $4 in EX, ID add $6,$4,$4 -> stall_id=1 one cycle, next ex_valid=0, then add issues
//  5 load-use and flush same cycle -> stall_id=0, ex_valid=0 next; wb to $0=0x55 -> ex_a=id_rd1
//  6 STALL_STATS_EN: 3 stalls, 2 flushes -> stat_stalls=3, stat_flushes=2; reset -> all 0

Source files
------------

// File: rtl/fwd_id_ex_stage.sv
// ID->EX pipeline register with writeback forwarding, load-use bubble insertion and branch flush.
// Optional counters are built when the STALL_STATS_EN macro is defined.
module fwd_id_ex_stage #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [CW-1:0] id_ctrl,
    input  logic          id_reg_write,
    input  logic          id_is_load,
    input  logic [RW-1:0] id_wr_regnum,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_regnum,
    input  logic [DW-1:0] wb_data,
    output logic          stall_id,
    output logic          ex_valid,
    output logic [CW-1:0] ex_ctrl,
    output logic          ex_reg_write,
    output logic          ex_is_load,
    output logic [RW-1:0] ex_wr_regnum,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]   stat_stalls,
    output logic [31:0]   stat_flushes,
    output logic [31:0]   stat_fwds
`endif
);

    logic          ex_valid_q,     ex_valid_d;
    logic [CW-1:0] ex_ctrl_q,      ex_ctrl_d;
    logic          ex_reg_write_q, ex_reg_write_d;
    logic          ex_is_load_q,   ex_is_load_d;
    logic [RW-1:0] ex_wr_regnum_q, ex_wr_regnum_d;
    logic [DW-1:0] ex_imm_q,       ex_imm_d;
    logic [RW-1:0] ex_rs_q,        ex_rs_d;
    logic [RW-1:0] ex_rt_q,        ex_rt_d;
    logic [DW-1:0] ex_rd1_q,       ex_rd1_d;
    logic [DW-1:0] ex_rd2_q,       ex_rd2_d;

    logic          hist_v_q [DEPTH];
    logic          hist_v_d [DEPTH];
    logic [RW-1:0] hist_r_q [DEPTH];
    logic [RW-1:0] hist_r_d [DEPTH];
    logic [DW-1:0] hist_d_q [DEPTH];
    logic [DW-1:0] hist_d_d [DEPTH];

    logic          load_use;
    logic          stall;
    logic          take;
    logic          hit_a;
    logic          hit_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // Hazard only looks at a real load in EX; a bubble has ex_valid=0 and never matches.
    always_comb begin
        load_use = ex_valid_q & ex_is_load_q & (ex_wr_regnum_q != '0) & id_valid &
                   ((id_uses_rs & (id_rs == ex_wr_regnum_q)) |
                    (id_uses_rt & (id_rt == ex_wr_regnum_q)));
        stall    = load_use & ~flush & ~reset;
        take     = id_valid & ~flush & ~load_use;
    end

    always_comb begin
        ex_valid_d     = 1'b0;
        ex_ctrl_d      = '0;
        ex_reg_write_d = 1'b0;
        ex_is_load_d   = 1'b0;
        ex_wr_regnum_d = '0;
        ex_imm_d       = '0;
        ex_rs_d        = '0;
        ex_rt_d        = '0;
        ex_rd1_d       = '0;
        ex_rd2_d       = '0;
        if (take) begin
            ex_valid_d     = 1'b1;
            ex_ctrl_d      = id_ctrl;
            ex_reg_write_d = id_reg_write;
            ex_is_load_d   = id_is_load;
            ex_wr_regnum_d = id_wr_regnum;
            ex_imm_d       = id_imm;
            ex_rs_d        = id_rs;
            ex_rt_d        = id_rt;
            ex_rd1_d       = id_rd1;
            ex_rd2_d       = id_rd2;
        end
    end

    always_comb begin
        hist_v_d[0] = wb_en;
        hist_r_d[0] = wb_regnum;
        hist_d_d[0] = wb_data;
        for (int i = 1; i < DEPTH; i++) begin
            hist_v_d[i] = hist_v_q[i-1];
            hist_r_d[i] = hist_r_q[i-1];
            hist_d_d[i] = hist_d_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_reg_write_q <= 1'b0;
            ex_is_load_q   <= 1'b0;
            ex_wr_regnum_q <= '0;
            ex_imm_q       <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd1_q       <= '0;
            ex_rd2_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_v_q[i] <= 1'b0;
                hist_r_q[i] <= '0;
                hist_d_q[i] <= '0;
            end
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_is_load_q   <= ex_is_load_d;
            ex_wr_regnum_q <= ex_wr_regnum_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_rd1_q       <= ex_rd1_d;
            ex_rd2_q       <= ex_rd2_d;
            for (int i = 0; i < DEPTH; i++) begin
                hist_v_q[i] <= hist_v_d[i];
                hist_r_q[i] <= hist_r_d[i];
                hist_d_q[i] <= hist_d_d[i];
            end
        end
    end

    // Oldest history first so newer entries, and finally the live port, override it.
    always_comb begin
        fwd_a = ex_rd1_q;
        fwd_b = ex_rd2_q;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hist_v_q[i] && (hist_r_q[i] == ex_rs_q) && (ex_rs_q != '0)) begin
                fwd_a = hist_d_q[i];
                hit_a = 1'b1;
            end
            if (hist_v_q[i] && (hist_r_q[i] == ex_rt_q) && (ex_rt_q != '0)) begin
                fwd_b = hist_d_q[i];
                hit_b = 1'b1;
            end
        end
        if (wb_en && (wb_regnum == ex_rs_q) && (ex_rs_q != '0)) begin
            fwd_a = wb_data;
            hit_a = 1'b1;
        end
        if (wb_en && (wb_regnum == ex_rt_q) && (ex_rt_q != '0)) begin
            fwd_b = wb_data;
            hit_b = 1'b1;
        end
    end

    assign stall_id     = stall;
    assign ex_valid     = ex_valid_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_is_load   = ex_is_load_q;
    assign ex_wr_regnum = ex_wr_regnum_q;
    assign ex_imm       = ex_imm_q;
    assign ex_a         = fwd_a;
    assign ex_b         = fwd_b;

`ifdef STALL_STATS_EN
    logic [31:0] stat_stalls_q,  stat_stalls_d;
    logic [31:0] stat_flushes_q, stat_flushes_d;
    logic [31:0] stat_fwds_q,    stat_fwds_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stat_stalls_d  = stat_stalls_q;
        stat_flushes_d = stat_flushes_q;
        stat_fwds_d    = stat_fwds_q;
        if (stall && (stat_stalls_q != 32'hFFFF_FFFF)) begin
            stat_stalls_d = stat_stalls_q + 32'd1;
        end
        if (flush && (stat_flushes_q != 32'hFFFF_FFFF)) begin
            stat_flushes_d = stat_flushes_q + 32'd1;
        end
        if (ex_valid_q && (hit_a || hit_b) && (stat_fwds_q != 32'hFFFF_FFFF)) begin
            stat_fwds_d = stat_fwds_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stalls_q  <= '0;
            stat_flushes_q <= '0;
            stat_fwds_q    <= '0;
        end else begin
            stat_stalls_q  <= stat_stalls_d;
            stat_flushes_q <= stat_flushes_d;
            stat_fwds_q    <= stat_fwds_d;
        end
    end

    assign stat_stalls  = stat_stalls_q;
    assign stat_flushes = stat_flushes_q;
    assign stat_fwds    = stat_fwds_q;
`endif

endmodule

// File: tb/tb_fwd_id_ex_stage.sv
// Bench for fwd_id_ex_stage: directed cycle table, then random traffic against a queue-based model.
// Counter checks are compiled in when STALL_STATS_EN is defined.
module tb_fwd_id_ex_stage;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int CW    = 16;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic        rst;
        logic        idv;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic        rw;
        logic        ld;
        logic [4:0]  wr;
        logic        fl;
        logic        wbe;
        logic [4:0]  wbr;
        logic [31:0] wbd;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic        chk;
        logic        e_stall;
        logic        e_valid;
        logic [15:0] e_ctrl;
        logic        ck_ab;
        logic [31:0] e_a;
        logic [31:0] e_b;
    } vec_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic        rw;
        logic        ld;
        logic [4:0]  wr;
    } mex_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  r;
        logic [31:0] d;
    } wb_t;

    // clock / reset / DUT
    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_rs, id_rt;
    logic          id_uses_rs, id_uses_rt;
    logic [DW-1:0] id_rd1, id_rd2, id_imm;
    logic [CW-1:0] id_ctrl;
    logic          id_reg_write, id_is_load;
    logic [RW-1:0] id_wr_regnum;
    logic          flush;
    logic          wb_en;
    logic [RW-1:0] wb_regnum;
    logic [DW-1:0] wb_data;
    logic          stall_id, ex_valid, ex_reg_write, ex_is_load;
    logic [CW-1:0] ex_ctrl;
    logic [RW-1:0] ex_wr_regnum;
    logic [DW-1:0] ex_imm, ex_a, ex_b;
`ifdef STALL_STATS_EN
    logic [31:0]   stat_stalls, stat_flushes, stat_fwds;
    logic [31:0]   m_stalls, m_flushes, m_fwds;
`endif

    fwd_id_ex_stage #(.DW(DW), .RW(RW), .CW(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_wr_regnum(id_wr_regnum),
        .flush(flush), .wb_en(wb_en), .wb_regnum(wb_regnum), .wb_data(wb_data),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_wr_regnum(ex_wr_regnum),
        .ex_imm(ex_imm), .ex_a(ex_a), .ex_b(ex_b)
`ifdef STALL_STATS_EN
        , .stat_stalls(stat_stalls), .stat_flushes(stat_flushes), .stat_fwds(stat_fwds)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    in_t  cur;
    mex_t m_ex;
    wb_t  m_hist[$];
    logic model_ok   = 1'b0;
    logic prev_stall = 1'b0;
    logic e_stall, hit_a, hit_b;
    logic [31:0] e_a, e_b;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic drive(input in_t v);
        cur          = v;
        reset        = v.rst;
        id_valid     = v.idv;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_uses_rs   = v.urs;
        id_uses_rt   = v.urt;
        id_rd1       = v.rd1;
        id_rd2       = v.rd2;
        id_imm       = v.imm;
        id_ctrl      = v.ctrl;
        id_reg_write = v.rw;
        id_is_load   = v.ld;
        id_wr_regnum = v.wr;
        flush        = v.fl;
        wb_en        = v.wbe;
        wb_regnum    = v.wbr;
        wb_data      = v.wbd;
    endtask

    // Reference model: newest writeback naming the register wins; $0 is never forwarded.
    function automatic logic [31:0] m_opnd(input logic [4:0] r, input logic [31:0] regval,
                                           output logic hit);
        hit = 1'b0;
        if (r == 5'd0) return regval;
        if (cur.wbe && cur.wbr == r) begin
            hit = 1'b1;
            return cur.wbd;
        end
        for (int k = 0; k < m_hist.size(); k++) begin
            if (m_hist[k].en && m_hist[k].r == r) begin
                hit = 1'b1;
                return m_hist[k].d;
            end
        end
        return regval;
    endfunction

    task automatic model_expect();
        e_stall = !cur.rst && !cur.fl && m_ex.v && m_ex.ld && (m_ex.wr != 5'd0) && cur.idv &&
                  ((cur.urs && cur.rs == m_ex.wr) || (cur.urt && cur.rt == m_ex.wr));
        e_a = m_opnd(m_ex.rs, m_ex.rd1, hit_a);
        e_b = m_opnd(m_ex.rt, m_ex.rd2, hit_b);
    endtask

    task automatic model_checks();
        chk("stall_id", 32'(stall_id), 32'(e_stall));
        chk("ex_valid", 32'(ex_valid), 32'(m_ex.v));
        chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ex.ctrl));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m_ex.rw));
        chk("ex_is_load", 32'(ex_is_load), 32'(m_ex.ld));
        chk("ex_wr_regnum", 32'(ex_wr_regnum), 32'(m_ex.wr));
        if (m_ex.v) begin
            chk("ex_imm", ex_imm, m_ex.imm);
            chk("ex_a", ex_a, e_a);
            chk("ex_b", ex_b, e_b);
        end
        chk("stall_repeat", 32'(stall_id & prev_stall), 32'd0);
        prev_stall = stall_id;
`ifdef STALL_STATS_EN
        chk("stat_stalls", stat_stalls, m_stalls);
        chk("stat_flushes", stat_flushes, m_flushes);
        chk("stat_fwds", stat_fwds, m_fwds);
`endif
    endtask

    task automatic model_update();
        if (cur.rst) begin
            m_ex = '0;
            m_hist.delete();
`ifdef STALL_STATS_EN
            m_stalls = 0; m_flushes = 0; m_fwds = 0;
`endif
        end else begin
`ifdef STALL_STATS_EN
            if (e_stall && m_stalls != 32'hFFFF_FFFF) m_stalls++;
            if (cur.fl && m_flushes != 32'hFFFF_FFFF) m_flushes++;
            if (m_ex.v && (hit_a || hit_b) && m_fwds != 32'hFFFF_FFFF) m_fwds++;
`endif
            m_hist.push_front('{en: cur.wbe, r: cur.wbr, d: cur.wbd});
            while (m_hist.size() > DEPTH) void'(m_hist.pop_back());
            if (cur.idv && !cur.fl && !e_stall)
                m_ex = '{v: 1'b1, rs: cur.rs, rt: cur.rt, rd1: cur.rd1, rd2: cur.rd2,
                         imm: cur.imm, ctrl: cur.ctrl, rw: cur.rw, ld: cur.ld, wr: cur.wr};
            else
                m_ex = '0;
        end
        model_ok = 1'b1;
    endtask

    task automatic step(input vec_t tv);
        drive(tv.i);
        @(negedge clk);
        model_expect();
        if (tv.chk) begin
            chk($sformatf("row%0d_stall", cyc), 32'(stall_id), 32'(tv.e_stall));
            chk($sformatf("row%0d_valid", cyc), 32'(ex_valid), 32'(tv.e_valid));
            chk($sformatf("row%0d_ctrl", cyc), 32'(ex_ctrl), 32'(tv.e_ctrl));
            if (tv.ck_ab) begin
                chk($sformatf("row%0d_a", cyc), ex_a, tv.e_a);
                chk($sformatf("row%0d_b", cyc), ex_b, tv.e_b);
            end
        end
        if (model_ok) model_checks();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic in_t id_in(input in_t b, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urs, input logic urt, input logic [31:0] rd1,
                                  input logic [31:0] rd2, input logic [31:0] imm,
                                  input logic [15:0] ctrl, input logic rw, input logic ld,
                                  input logic [4:0] wr);
        in_t n = b;
        n.idv = 1'b1; n.rs = rs; n.rt = rt; n.urs = urs; n.urt = urt;
        n.rd1 = rd1; n.rd2 = rd2; n.imm = imm; n.ctrl = ctrl; n.rw = rw; n.ld = ld; n.wr = wr;
        return n;
    endfunction

    function automatic in_t wb_in(input in_t b, input logic [4:0] r, input logic [31:0] d);
        in_t n = b;
        n.wbe = 1'b1; n.wbr = r; n.wbd = d;
        return n;
    endfunction

    task automatic add_vec(input in_t i, input logic c, input logic s, input logic v,
                           input logic [15:0] ct, input logic ab, input logic [31:0] a,
                           input logic [31:0] b);
        vec_t t;
        t.i = i; t.chk = c; t.e_stall = s; t.e_valid = v; t.e_ctrl = ct;
        t.ck_ab = ab; t.e_a = a; t.e_b = b;
        vecs.push_back(t);
    endtask

    function automatic in_t rand_in(input in_t prev, input logic hold);
        in_t n;
        logic [31:0] t;
        n = '0;
        if (hold) begin
            n = prev;
        end else begin
            n.idv = ($urandom_range(0, 3) != 0);
            n.rs  = 5'($urandom_range(0, 3));
            n.rt  = 5'($urandom_range(0, 3));
            n.urs = 1'($urandom_range(0, 1));
            n.urt = 1'($urandom_range(0, 1));
            n.rd1 = $urandom;
            n.rd2 = $urandom;
            n.imm = $urandom;
            t = $urandom;
            n.ctrl = t[15:0];
            n.rw  = 1'($urandom_range(0, 1));
            n.ld  = ($urandom_range(0, 2) == 0);
            n.wr  = 5'($urandom_range(0, 3));
        end
        n.rst = ($urandom_range(0, 59) == 0);
        n.fl  = ($urandom_range(0, 9) == 0);
        n.wbe = 1'($urandom_range(0, 1));
        n.wbr = 5'($urandom_range(0, 3));
        n.wbd = $urandom;
        return n;
    endfunction

    initial begin
        in_t  z, r, lw4, add6, lw8, use8;
        vec_t rv;
        logic last_stall;

        z = '0;
        r = z; r.rst = 1'b1;
        add_vec(r, 0, 0, 0, 16'h0, 0, 0, 0);
        add_vec(r, 1, 0, 0, 16'h0, 1, 0, 0);
        add_vec(z, 1, 0, 0, 16'h0, 1, 0, 0);
        // live writeback beats the stale register-file value
        add_vec(id_in(z, 1, 2, 1, 1, 32'h7, 32'h8, 0, 16'h0021, 1, 0, 3), 1, 0, 0, 16'h0, 0, 0, 0);
        add_vec(id_in(z, 3, 2, 1, 1, 32'hDEAD, 32'h8, 0, 16'h0022, 1, 0, 7), 1, 0, 1, 16'h0021, 1, 32'h7, 32'h8);
        add_vec(wb_in(z, 3, 32'h11), 1, 0, 1, 16'h0022, 1, 32'h11, 32'h8);
        // two history writes to $5: newest wins
        add_vec(wb_in(z, 5, 32'hAA), 1, 0, 0, 16'h0, 0, 0, 0);
        add_vec(wb_in(id_in(z, 5, 5, 1, 1, 32'h1, 32'h2, 0, 16'h0033, 0, 0, 0), 5, 32'hBB), 1, 0, 0, 16'h0, 0, 0, 0);
        add_vec(z, 1, 0, 1, 16'h0033, 1, 32'hBB, 32'hBB);
        // load-use: one stall, one bubble, then the consumer issues
        lw4  = id_in(z, 1, 0, 1, 0, 32'h100, 0, 32'h4, 16'h0044, 1, 1, 4);
        add6 = id_in(z, 4, 4, 1, 1, 32'hBAD, 32'hBAD, 0, 16'h0055, 1, 0, 6);
        add_vec(lw4, 1, 0, 0, 16'h0, 0, 0, 0);
        add_vec(add6, 1, 1, 1, 16'h0044, 1, 32'h100, 0);
        add_vec(wb_in(add6, 4, 32'h77), 1, 0, 0, 16'h0, 0, 0, 0);
        add_vec(z, 1, 0, 1, 16'h0055, 1, 32'h77, 32'h77);
        // flush beats load-use; $0 writeback is never forwarded
        lw8  = id_in(z, 2, 0, 1, 0, 32'h200, 0, 0, 16'h0066, 1, 1, 8);
        use8 = id_in(z, 8, 0, 1, 0, 32'h1234, 0, 0, 16'h0077, 1, 0, 9);
        use8.fl = 1'b1;
        add_vec(lw8, 1, 0, 0, 16'h0, 0, 0, 0);
        add_vec(use8, 1, 0, 1, 16'h0066, 1, 32'h200, 0);
        add_vec(wb_in(id_in(z, 0, 0, 1, 0, 32'h42, 0, 0, 16'h0088, 0, 0, 0), 0, 32'h55), 1, 0, 0, 16'h0, 0, 0, 0);
        add_vec(wb_in(z, 0, 32'h55), 1, 0, 1, 16'h0088, 1, 32'h42, 0);
        // mid-stream reset: pre-reset writeback must not forward afterwards
        add_vec(wb_in(id_in(z, 9, 0, 1, 0, 32'h3, 0, 0, 16'h0099, 1, 0, 0), 9, 32'h99), 1, 0, 0, 16'h0, 0, 0, 0);
        r = wb_in(z, 9, 32'h99); r.rst = 1'b1;
        add_vec(r, 1, 0, 1, 16'h0099, 1, 32'h99, 0);
        add_vec(id_in(z, 9, 0, 1, 0, 32'h4, 0, 0, 16'h00AA, 0, 0, 0), 1, 0, 0, 16'h0, 1, 0, 0);
        add_vec(z, 1, 0, 1, 16'h00AA, 1, 32'h4, 0);

        for (int k = 0; k < vecs.size(); k++) step(vecs[k]);

        rv = '0;
        last_stall = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rv.i = rand_in(cur, last_stall);
            step(rv);
            last_stall = e_stall;
        end

`ifdef STALL_STATS_EN
        rv = '0;
        rv.i = z; rv.i.rst = 1'b1;
        step(rv);
        for (int k = 0; k < 3; k++) begin
            rv.i = lw4;  step(rv);
            rv.i = add6; step(rv);
            rv.i = add6; step(rv);
        end
        rv.i = z; rv.i.fl = 1'b1;
        step(rv);
        step(rv);
        rv.i = z;
        step(rv);
        chk("dir_stat_stalls", stat_stalls, 32'd3);
        chk("dir_stat_flushes", stat_flushes, 32'd2);
        rv.i.rst = 1'b1;
        step(rv);
        chk("dir_stat_stalls_rst", stat_stalls, 32'd0);
        chk("dir_stat_flushes_rst", stat_flushes, 32'd0);
        chk("dir_stat_fwds_rst", stat_fwds, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
